pic_inta_eoi_ctrl: RTL and testbench
====================================

Name: pic_inta_eoi_ctrl

Overview:
- CPU-side interrupt acknowledge and end-of-interrupt controller for the 8259A PIC, operating in 8086 mode.
- Takes latched requests from the IRR block and asserts INT to the CPU.
- Sequences the two-pulse INTA cycle: sets the winning in-service bit, clears its request bit, and drives the 8-bit vector on the second INTA.
- Clears in-service bits on specific, non-specific or automatic EOI. This block owns and writes the in-service register that the ISR/priority logic reads.

Parameters:
- INTA_TIMEOUT, 15, number of cycles spent in GAP without a second INTA falling edge before the cycle is aborted.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irr  input  8  latched interrupt requests; bit 0 has the highest priority.
- imr  input  8  interrupt mask; 1 masks that IR.
- inta_n  input  1  CPU acknowledge, active low, synchronous to clk.
- eoi_cmd  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  with eoi_cmd: 1 = specific EOI, 0 = non-specific EOI.
- eoi_level  input  3  IR level cleared by a specific EOI.
- aeoi  input  1  automatic EOI mode enable.
- vector_base  input  5  ICW2 bits T7..T3.
- int_out  output  1  interrupt request to the CPU.
- isr  output  8  in-service register.
- clr_irr  output  8  one-cycle pulse that clears the matching IRR bit.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE, isr=0, clr_irr=0, data_out=0, data_oe=0, int_out=0, inta_prev=1, timeout counter=0, latched index=0.
- Reset is legal mid-cycle; any partially set ISR bit is dropped.

Priority:
- req = irr & ~imr.
- winner = lowest set index of req.
- top_isr = lowest set index of isr.
- int_out is registered (1-cycle latency). It is 1 only when state=IDLE, req!=0, and (isr==0 or winner<top_isr). Otherwise it is 0.

Edges:
- fall = inta_prev & ~inta_n.
- rise = ~inta_prev & inta_n.
- inta_prev is registered every cycle.

FSM:
- IDLE: on fall -> ACK1.
  - If req!=0: latch idx=winner, set isr[idx], pulse clr_irr[idx] for exactly one cycle.
  - Else (spurious): idx=7, isr and clr_irr unchanged, spurious flag=1.
  - data_oe stays 0.
- ACK1: wait for rise -> GAP; clear the timeout counter on entry. data_oe=0.
- GAP:
  - On fall -> ACK2. data_out={vector_base,idx} and data_oe=1, both registered and visible the cycle after the fall.
  - If the counter reaches INTA_TIMEOUT -> IDLE; clear isr[idx] unless spurious.
- ACK2: hold data_out and data_oe while inta_n is low. On rise: data_oe=0; if aeoi and not spurious, clear isr[idx]; -> IDLE.

EOI:
- Accepted in any state.
- Non-specific: clears isr[top_isr]; no effect if isr==0.
- Specific: clears isr[eoi_level]; no effect if that bit is already 0.

Simultaneous events:
- isr_next = (isr & ~eoi_mask & ~aeoi_mask & ~timeout_mask) | set_mask.
- All masks are computed from the current isr, so a set wins over a clear on the same bit in the same cycle.

Other rules:
- irr/imr changes during ACK1..ACK2 do not alter idx.
- Edges of inta_n outside the states above are ignored.
- A held-low inta_n produces only one fall.

Test Plan:
1. Basic ack. irr=8'b1010_1010, imr=0, vector_base=5'b01000, isr=0 -> int_out=1. INTA pair -> isr=8'b0000_0010, clr_irr=8'b0000_0010 for one cycle, data_out=8'h41 with data_oe=1 during the second INTA. Non-specific EOI -> isr=0.
2. Nesting. isr=8'b0000_1000, irr=8'b0010_0000 -> int_out=0. Then irr=8'b0000_0100 -> int_out=1. The ack sets isr=8'b0000_1100. Specific EOI level 3 -> isr=8'b0000_0100.
3. Spurious. irr=0 at the first INTA fall -> isr and clr_irr unchanged; second INTA gives data_out={vector_base,3'b111}.
4. AEOI. aeoi=1, irr=8'b1000_0000 -> isr bit 7 set after the first INTA and cleared on the second INTA rise; isr=0 in IDLE.
5. Timeout and collision.
   - First INTA only, then no second INTA for 15 cycles -> isr bit cleared, state back to IDLE.
   - Specific EOI for bit 2 in the same cycle the ack sets bit 2 -> bit 2 remains 1.
6. Reset mid-ACK2. Assert rst_n=0 while data_oe=1 -> data_oe, isr and int_out are 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pic_inta_eoi_ctrl.sv
// 8259A (8086 mode) INTA sequencer and EOI handler. This block owns the in-service register.
// It raises INT to the CPU, runs the two-pulse acknowledge, drives the vector and clears ISR bits.
module pic_inta_eoi_ctrl #(
  parameter int INTA_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clr_irr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK1 = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] ACK2 = 2'd3;

  localparam int CW = $clog2(INTA_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(INTA_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    isr_q, isr_d;
  logic [7:0]    clr_irr_q, clr_irr_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_oe_q, data_oe_d;
  logic          int_out_q, int_out_d;
  logic          inta_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          spur_q, spur_d;

  logic [7:0] req;
  logic       req_any;
  logic [2:0] winner;
  logic [2:0] top_isr;
  logic       fall;
  logic       rise;
  logic [7:0] idx_mask;
  logic [7:0] set_mask;
  logic [7:0] eoi_mask;
  logic [7:0] aeoi_mask;
  logic [7:0] to_mask;

  always_comb begin
    req     = irr & ~imr;
    req_any = |req;
    winner  = 3'd0;
    top_isr = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i])   winner  = 3'(i);
      if (isr_q[i]) top_isr = 3'(i);
    end
    fall     = inta_prev_q & ~inta_n;
    rise     = ~inta_prev_q & inta_n;
    idx_mask = 8'd1 << idx_q;
  end

  // All clear masks look at the current ISR, so a set on the same bit always wins.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spur_d     = spur_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    clr_irr_d  = 8'd0;
    set_mask   = 8'd0;
    aeoi_mask  = 8'd0;
    to_mask    = 8'd0;
    eoi_mask   = 8'd0;

    if (eoi_cmd) begin
      if (eoi_specific) eoi_mask = 8'd1 << eoi_level;
      else              eoi_mask = isr_q & (~isr_q + 8'd1);
    end

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (fall) begin
          state_d = ACK1;
          if (req_any) begin
            idx_d     = winner;
            spur_d    = 1'b0;
            set_mask  = 8'd1 << winner;
            clr_irr_d = 8'd1 << winner;
          end else begin
            idx_d  = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        data_oe_d = 1'b0;
        if (rise) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (fall) begin
          state_d    = ACK2;
          data_out_d = {vector_base, idx_q};
          data_oe_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (!spur_q) to_mask = idx_mask;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK2: begin
        if (rise) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          if (aeoi && !spur_q) aeoi_mask = idx_mask;
        end
      end
      default: state_d = IDLE;
    endcase

    isr_d     = (isr_q & ~eoi_mask & ~aeoi_mask & ~to_mask) | set_mask;
    int_out_d = (state_q == IDLE) && req_any && (!(|isr_q) || (winner < top_isr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      isr_q       <= 8'd0;
      clr_irr_q   <= 8'd0;
      data_out_q  <= 8'd0;
      data_oe_q   <= 1'b0;
      int_out_q   <= 1'b0;
      inta_prev_q <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      clr_irr_q   <= clr_irr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      int_out_q   <= int_out_d;
      inta_prev_q <= inta_n;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      spur_q      <= spur_d;
    end
  end

  assign int_out  = int_out_q;
  assign isr      = isr_q;
  assign clr_irr  = clr_irr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_pic_inta_eoi_ctrl.sv
// Bench for pic_inta_eoi_ctrl: directed scenarios followed by random acknowledge/EOI traffic,
// checked against a transaction-level model of the in-service register.
module tb_pic_inta_eoi_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [7:0] data_out;
  logic       data_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] mIsr;
  int         mIdx;
  bit         mSpur;

  pic_inta_eoi_ctrl #(.INTA_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta_n(inta_n),
    .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .aeoi(aeoi), .vector_base(vector_base), .int_out(int_out), .isr(isr),
    .clr_irr(clr_irr), .data_out(data_out), .data_oe(data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowestSet(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An interrupt is offered when an unmasked request outranks everything in service.
  task automatic checkInt(input string tag);
    int w, t;
    tick();
    tick();
    w = lowestSet(irr & ~imr);
    t = lowestSet(mIsr);
    checkOutput(tag, 8'(int_out), 8'((w >= 0) && (t < 0 || w < t)));
  endtask

  task automatic ackFirst(input bit collide);
    int w;
    logic [7:0] setm;
    w    = lowestSet(irr & ~imr);
    setm = (w >= 0) ? (8'd1 << w) : 8'd0;
    inta_n = 1'b0;
    if (collide && w >= 0) begin
      eoi_cmd      = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = 3'(w);
    end
    tick();
    eoi_cmd = 1'b0;
    if (w >= 0) begin
      mIdx  = w;
      mSpur = 1'b0;
      mIsr  = mIsr | setm;
    end else begin
      mIdx  = 7;
      mSpur = 1'b1;
    end
    checkOutput("ack1_isr", isr, mIsr);
    checkOutput("ack1_clr_irr", clr_irr, setm);
    irr = irr & ~setm;
    tick();
    checkOutput("clr_irr_one_cycle", clr_irr, 8'd0);
    checkOutput("ack1_oe", 8'(data_oe), 8'd0);
    inta_n = 1'b1;
    tick();
    checkOutput("gap_int_out", 8'(int_out), 8'd0);
  endtask

  task automatic ackSecond(input int gap);
    repeat (gap) tick();
    inta_n = 1'b0;
    tick();
    checkOutput("vector", data_out, {vector_base, 3'(mIdx)});
    checkOutput("oe_on", 8'(data_oe), 8'd1);
    tick();
    checkOutput("oe_hold", 8'(data_oe), 8'd1);
    inta_n = 1'b1;
    tick();
    if (aeoi && !mSpur) mIsr[mIdx] = 1'b0;
    checkOutput("oe_off", 8'(data_oe), 8'd0);
    checkOutput("ack2_isr", isr, mIsr);
  endtask

  task automatic applyStimulus(input bit spec, input logic [2:0] lvl);
    int t;
    eoi_cmd      = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    tick();
    eoi_cmd = 1'b0;
    if (spec) mIsr[lvl] = 1'b0;
    else begin
      t = lowestSet(mIsr);
      if (t >= 0) mIsr[t] = 1'b0;
    end
    checkOutput(spec ? "eoi_specific" : "eoi_nonspecific", isr, mIsr);
  endtask

  initial begin
    rst_n = 1'b0; irr = 8'd0; imr = 8'd0; inta_n = 1'b1; eoi_cmd = 1'b0;
    eoi_specific = 1'b0; eoi_level = 3'd0; aeoi = 1'b0; vector_base = 5'b01000;
    mIsr = 8'd0; mIdx = 0; mSpur = 1'b0;
    #12;
    checkOutput("reset_isr", isr, 8'd0);
    checkOutput("reset_int", 8'(int_out), 8'd0);
    checkOutput("reset_oe", 8'(data_oe), 8'd0);
    checkOutput("reset_data", data_out, 8'd0);
    checkOutput("reset_clr", clr_irr, 8'd0);
    rst_n = 1'b1;
    tick();

    // Basic acknowledge
    irr = 8'b1010_1010;
    checkInt("basic_int");
    ackFirst(1'b0);
    checkOutput("basic_isr_const", isr, 8'h02);
    ackSecond(2);
    applyStimulus(1'b0, 3'd0);

    // Nesting
    irr = 8'b0000_1000;
    checkInt("nest_int_a");
    ackFirst(1'b0);
    ackSecond(1);
    irr = 8'b0010_0000;
    checkInt("nest_int_lower");
    irr = 8'b0000_0100;
    checkInt("nest_int_higher");
    ackFirst(1'b0);
    checkOutput("nest_isr_const", isr, 8'h0C);
    ackSecond(3);
    applyStimulus(1'b1, 3'd3);
    checkOutput("nest_after_eoi", isr, 8'h04);
    applyStimulus(1'b0, 3'd0);

    // Spurious
    irr = 8'd0;
    ackFirst(1'b0);
    ackSecond(0);

    // AEOI
    aeoi = 1'b1;
    irr  = 8'b1000_0000;
    ackFirst(1'b0);
    checkOutput("aeoi_set", isr, 8'h80);
    ackSecond(2);
    checkOutput("aeoi_clear", isr, 8'h00);
    aeoi = 1'b0;

    // Timeout with no second INTA
    irr = 8'b0001_0000;
    ackFirst(1'b0);
    repeat (5) tick();
    checkOutput("timeout_hold", isr, mIsr);
    repeat (15) tick();
    if (!mSpur) mIsr[mIdx] = 1'b0;
    checkOutput("timeout_isr", isr, mIsr);
    irr = 8'b0000_0001;
    checkInt("timeout_idle_int");

    // Set and specific EOI on the same bit in the same cycle
    irr = 8'b0000_0100;
    ackFirst(1'b1);
    ackSecond(1);
    checkOutput("collide_bit2", 8'(isr[2]), 8'd1);
    applyStimulus(1'b1, 3'd2);

    // Asynchronous reset during the second acknowledge
    irr = 8'b0000_0010;
    ackFirst(1'b0);
    inta_n = 1'b0;
    tick();
    checkOutput("pre_reset_oe", 8'(data_oe), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_oe", 8'(data_oe), 8'd0);
    checkOutput("async_reset_isr", isr, 8'd0);
    checkOutput("async_reset_int", 8'(int_out), 8'd0);
    inta_n = 1'b1;
    mIsr = 8'd0;
    #1 rst_n = 1'b1;
    tick();

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      irr  = 8'($urandom);
      imr  = 8'($urandom) & 8'($urandom);
      aeoi = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) irr = 8'd0;
      checkInt("rand_int");
      if ($urandom_range(0, 2) != 0) begin
        ackFirst(1'b0);
        ackSecond(int'($urandom_range(0, 5)));
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
